tvs_ulpi_phy_ctrl: RTL and testbench
====================================

# tvs_ulpi_phy_ctrl

PHY-side ULPI bus controller for the USB2 device VIP: owns `dir`, `nxt` and `data_out` on the ULPI bus, and sequences all bus traffic. Traffic types: link-initiated TX commands (transmit, register write, register read) and PHY-initiated RX CMD and RX packet transfers. Decodes link TX CMD bytes, throttles transmit data, serves register accesses, and inserts turnaround cycles. Sits between the ULPI interface signals and the VIP's RX source, TX sink and PHY register model.

## Interface
- `ULPI_DATA_WIDTH`, 8, ULPI data width; only 8 is legal.
- `clock`  in  1  ULPI clock; all state changes on posedge.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `stp`  in  1  link stop.
- `data_in`  in  8  link-driven ULPI data.
- `dir`  out  1  PHY owns bus when 1.
- `nxt`  out  1  PHY throttle/accept.
- `data_out`  out  8  PHY-driven ULPI data.
- `rx_req`  in  1  RX packet pending.
- `rx_valid`, `rx_last`  in  1  RX byte stream qualifiers.
- `rx_data`  in  8  RX byte.
- `rx_ready`  out  1  RX byte consumed at this edge when `rx_valid`.
- `rxcmd_req`  in  1  RX CMD update pending.
- `rxcmd_data`  in  8  current RX CMD byte (linestate, events).
- `rxcmd_ack`  out  1  one-cycle pulse: RX CMD sent.
- `tx_ready`  in  1  TX sink can accept a byte.
- `tx_cmd_valid`  out  1  pulse: transmit TX CMD accepted.
- `tx_data_valid`  out  1  pulse: transmit data byte accepted.
- `tx_data`  out  8  accepted TX CMD or data byte.
- `tx_done`  out  1  pulse: transmit ended by `stp`.
- `reg_we`  out  1  pulse: register write.
- `reg_addr`  out  6  register address from TX CMD[5:0].
- `reg_wdata`  out  8  register write data.
- `reg_rdata`  in  8  combinational read data for `reg_addr`.

## Operation
- All outputs registered except `rx_ready`, which is `state==RXDATA`.
- "Accept edge": posedge with `dir==0`, `nxt==1` (registered value) and `stp==0`. At an accept edge, `data_in` is consumed.
- States: IDLE, TXCMD, TXDATA, REGW_DATA, REGW_STP, REGR_TURN, REGR_DATA, TURN_PHY, RXCMD, RXDATA, RXEND, TURN_LINK.
- **IDLE** (`dir=0`, `nxt=0`, `data_out=0`):
  - If `rxcmd_req|rx_req`, go to TURN_PHY with `dir<=1`. The PHY wins over a simultaneous link TX CMD, which is dropped; the link retries.
  - Else if `data_in[7:6]!=00`, latch `reg_addr<=data_in[5:0]`, go to TXCMD with `nxt<=1`.
  - `data_in[7:6]==00` is ignored.
- **TXCMD**: at the accept edge, decode the latched cmd:
  - 01: pulse `tx_cmd_valid` with `tx_data<=cmd`; go to TXDATA with `nxt<=tx_ready`.
  - 10: go to REGW_DATA with `nxt<=1`.
  - 11: go to REGR_TURN with `dir<=1`, `nxt<=0`.
- **TXDATA**:
  - Each accept edge pulses `tx_data_valid` with `tx_data<=data_in`.
  - `nxt<=tx_ready` every edge.
  - Edge with `stp=1`: pulse `tx_done`, `nxt<=0`, go to IDLE.
- **REGW_DATA**: at the accept edge, `reg_wdata<=data_in`, `nxt<=0`, go to REGW_STP.
- **REGW_STP**: at the edge with `stp=1`, pulse `reg_we`, go to IDLE. Otherwise wait.
- **REGR_TURN** (turnaround): `data_out<=reg_rdata`, go to REGR_DATA.
- **REGR_DATA**: one cycle; then `dir<=0`, `data_out<=0`, go to TURN_LINK.
- **TURN_PHY** (turnaround, `data_out=0`, `nxt=0`):
  - If `rxcmd_req`, go to RXCMD with `data_out<=rxcmd_data` and pulse `rxcmd_ack`.
  - Else go to RXDATA.
- **RXCMD**: one cycle; then go to RXDATA if `rx_req`, else go to TURN_LINK with `dir<=0`.
- **RXDATA**:
  - If `rx_valid`: `data_out<=rx_data`, `nxt<=1`. If `rx_last`, go to RXEND.
  - If `!rx_valid`: `data_out<=rxcmd_data`, `nxt<=0` (RX CMD filler).
- **RXEND**: the last byte is shown with `nxt=1`; then `dir<=0`, `nxt<=0`, go to TURN_LINK.
- **TURN_LINK**: `data_in` and `stp` are ignored for one cycle; then go to IDLE.
- `rx_req` and `rxcmd_req` asserted during any non-IDLE state are deferred until IDLE.

## Timing
- Reset (asynchronous, any state): state IDLE, all outputs 0.
- TX CMD sampled at edge N: `nxt=1` from N+1. Accept edge at N+1 gives `tx_cmd_valid` high in cycle N+2.
- PHY request seen at edge N: `dir=1` from N+1 (turnaround). First valid `data_out` in cycle N+2.
- Register read: cmd accepted at edge A; `dir=1` in A+1; `data_out=reg_rdata` in A+2; `dir=0` in A+3.
- Minimum RX transfer: 1 turnaround + N bytes + RXEND + 1 turnaround.
- `stp` during RXDATA is ignored.

## Test plan
- **Transmit:**
  - Stimulus: link drives 0x41, holds until `nxt`, sends bytes 0xC3, 0x5A with `tx_ready=1`, then `stp`.
  - Response: `tx_cmd_valid` with 0x41, two `tx_data_valid` pulses (0xC3, 0x5A), one `tx_done`, `nxt` low after.
- **Register write:**
  - Stimulus: cmd 0x8A, data 0x3C, `stp`.
  - Response: single `reg_we` pulse with `reg_addr=0x0A`, `reg_wdata=0x3C`; `dir` stays 0.
- **Register read:**
  - Stimulus: cmd 0xC4 with `reg_rdata=0x77`.
  - Response: `dir` high exactly 2 cycles; `data_out=0x77` in the second cycle with `nxt=0`.
- **RX packet:**
  - Stimulus: `rxcmd_req`+`rx_req`, bytes 0x2D, 0x00, 0x10 with `rx_valid` low for one cycle mid-stream.
  - Response: turnaround, RX CMD, then data with `nxt=1`; the gap cycle shows `rxcmd_data` with `nxt=0`; `dir` drops after RXEND.
- **Collision:**
  - Stimulus: `rx_req` and `data_in=0x41` sampled at the same IDLE edge.
  - Response: `dir=1` next cycle; no `tx_cmd_valid`.
- **Reset mid-TXDATA:**
  - Stimulus: assert `reset` asynchronously mid-cycle during TXDATA.
  - Response: `dir`/`nxt` go to 0 immediately; after release, a new 0x41 transmit completes normally.

Source files
------------

// File: rtl/tvs_ulpi_phy_ctrl.sv
// tvs_ulpi_phy_ctrl: PHY-side ULPI bus sequencer for TX commands, register access and RX traffic.
module tvs_ulpi_phy_ctrl #(
    parameter int ULPI_DATA_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       stp,
    input  logic [ULPI_DATA_WIDTH-1:0] data_in,
    output logic                       dir,
    output logic                       nxt,
    output logic [ULPI_DATA_WIDTH-1:0] data_out,
    input  logic                       rx_req,
    input  logic                       rx_valid,
    input  logic                       rx_last,
    input  logic [ULPI_DATA_WIDTH-1:0] rx_data,
    output logic                       rx_ready,
    input  logic                       rxcmd_req,
    input  logic [ULPI_DATA_WIDTH-1:0] rxcmd_data,
    output logic                       rxcmd_ack,
    input  logic                       tx_ready,
    output logic                       tx_cmd_valid,
    output logic                       tx_data_valid,
    output logic [ULPI_DATA_WIDTH-1:0] tx_data,
    output logic                       tx_done,
    output logic                       reg_we,
    output logic [5:0]                 reg_addr,
    output logic [ULPI_DATA_WIDTH-1:0] reg_wdata,
    input  logic [ULPI_DATA_WIDTH-1:0] reg_rdata
);
    typedef enum logic [3:0] {
        IDLE, TXCMD, TXDATA, REGW_DATA, REGW_STP, REGR_TURN,
        REGR_DATA, TURN_PHY, RXCMD, RXDATA, RXEND, TURN_LINK
    } state_t;

    state_t     state;
    logic [1:0] kind;
    logic       accept;

    assign accept   = !dir && nxt && !stp;
    assign rx_ready = state == RXDATA;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            kind          <= '0;
            dir           <= 1'b0;
            nxt           <= 1'b0;
            data_out      <= '0;
            rxcmd_ack     <= 1'b0;
            tx_cmd_valid  <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_data       <= '0;
            tx_done       <= 1'b0;
            reg_we        <= 1'b0;
            reg_addr      <= '0;
            reg_wdata     <= '0;
        end else begin
            rxcmd_ack     <= 1'b0;
            tx_cmd_valid  <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_done       <= 1'b0;
            reg_we        <= 1'b0;
            case (state)
                IDLE: begin
                    // PHY traffic wins; a colliding link command is dropped and retried
                    if (rxcmd_req || rx_req) begin
                        dir   <= 1'b1;
                        state <= TURN_PHY;
                    end else if (data_in[7:6] != 2'b00) begin
                        kind     <= data_in[7:6];
                        reg_addr <= data_in[5:0];
                        nxt      <= 1'b1;
                        state    <= TXCMD;
                    end
                end
                TXCMD: begin
                    if (accept) begin
                        case (kind)
                            2'b01: begin
                                tx_cmd_valid <= 1'b1;
                                tx_data      <= {kind, reg_addr};
                                nxt          <= tx_ready;
                                state        <= TXDATA;
                            end
                            2'b10: state <= REGW_DATA;
                            default: begin
                                dir   <= 1'b1;
                                nxt   <= 1'b0;
                                state <= REGR_TURN;
                            end
                        endcase
                    end
                end
                TXDATA: begin
                    if (stp) begin
                        tx_done <= 1'b1;
                        nxt     <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (accept) begin
                            tx_data_valid <= 1'b1;
                            tx_data       <= data_in;
                        end
                        nxt <= tx_ready;
                    end
                end
                REGW_DATA: begin
                    if (accept) begin
                        reg_wdata <= data_in;
                        nxt       <= 1'b0;
                        state     <= REGW_STP;
                    end
                end
                REGW_STP: begin
                    if (stp) begin
                        reg_we <= 1'b1;
                        state  <= IDLE;
                    end
                end
                REGR_TURN: begin
                    data_out <= reg_rdata;
                    state    <= REGR_DATA;
                end
                REGR_DATA: begin
                    dir      <= 1'b0;
                    data_out <= '0;
                    state    <= TURN_LINK;
                end
                TURN_PHY: begin
                    if (rxcmd_req) begin
                        data_out  <= rxcmd_data;
                        rxcmd_ack <= 1'b1;
                        state     <= RXCMD;
                    end else begin
                        state <= RXDATA;
                    end
                end
                RXCMD: begin
                    if (rx_req) begin
                        state <= RXDATA;
                    end else begin
                        dir      <= 1'b0;
                        data_out <= '0;
                        state    <= TURN_LINK;
                    end
                end
                RXDATA: begin
                    // idle gaps in the stream show the current RX CMD with nxt low
                    data_out <= rx_valid ? rx_data : rxcmd_data;
                    nxt      <= rx_valid;
                    if (rx_valid && rx_last) state <= RXEND;
                end
                RXEND: begin
                    dir      <= 1'b0;
                    nxt      <= 1'b0;
                    data_out <= '0;
                    state    <= TURN_LINK;
                end
                TURN_LINK: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tvs_ulpi_phy_ctrl.sv
// tb_tvs_ulpi_phy_ctrl: per-cycle trace checks of the ULPI PHY controller against a scenario model.
module tb_tvs_ulpi_phy_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       stp = 1'b0;
    logic [7:0] data_in = '0;
    logic       rx_req = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_last = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rxcmd_req = 1'b0;
    logic [7:0] rxcmd_data = '0;
    logic       tx_ready = 1'b1;
    logic [7:0] reg_rdata = '0;
    logic       dir, nxt, rx_ready, rxcmd_ack, tx_cmd_valid, tx_data_valid, tx_done, reg_we;
    logic [7:0] data_out, tx_data, reg_wdata;
    logic [5:0] reg_addr;

    tvs_ulpi_phy_ctrl #(.ULPI_DATA_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .stp(stp), .data_in(data_in),
        .dir(dir), .nxt(nxt), .data_out(data_out),
        .rx_req(rx_req), .rx_valid(rx_valid), .rx_last(rx_last), .rx_data(rx_data),
        .rx_ready(rx_ready), .rxcmd_req(rxcmd_req), .rxcmd_data(rxcmd_data),
        .rxcmd_ack(rxcmd_ack), .tx_ready(tx_ready), .tx_cmd_valid(tx_cmd_valid),
        .tx_data_valid(tx_data_valid), .tx_data(tx_data), .tx_done(tx_done),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 clock = ~clock;

    // One record per clock edge: inputs presented before the edge, outputs expected after it.
    typedef struct packed {
        logic       stp, rx_req, rxcmd_req, rx_valid, rx_last, tx_ready;
        logic [7:0] din, rx_data, rxcmd_data, rdata;
        logic       dir, nxt, tcv, tdv, done, we, ack, rdy;
        logic [7:0] dout, txd, wdata;
        logic [5:0] addr;
    } cyc_t;

    cyc_t       q[$];
    int         tests = 0, fails = 0, cyc_n = 0;
    int         n_tcv = 0, n_done = 0, n_we = 0, n_ack = 0, n_dir = 0, n77 = 0;
    int         b_tcv, b_done, b_we, b_ack, b_dir, b77;
    logic [7:0] got[$];

    function automatic cyc_t blank();
        cyc_t c;
        c = '0;
        c.tx_ready = 1'b1;
        return c;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(blank());
    endtask

    // Transmit model: link holds each byte until nxt was high at an edge; nxt follows tx_ready.
    task automatic gen_tx(input logic [7:0] cmd, input logic [31:0] bytes, input int n,
                          input logic [15:0] rdy);
        cyc_t c;
        logic nprev;
        int   j, k;
        c = blank(); c.din = cmd; c.nxt = 1'b1; q.push_back(c);
        c = blank(); c.din = cmd; c.tx_ready = rdy[0]; c.nxt = rdy[0];
        c.tcv = 1'b1; c.txd = cmd; q.push_back(c);
        nprev = rdy[0];
        j = 0;
        k = 1;
        while (j < n && k < 16) begin
            c = blank();
            c.din = bytes[8*j+:8];
            c.tx_ready = rdy[k];
            c.nxt = rdy[k];
            if (nprev) begin
                c.tdv = 1'b1;
                c.txd = bytes[8*j+:8];
                j++;
            end
            nprev = rdy[k];
            k++;
            q.push_back(c);
        end
        c = blank(); c.stp = 1'b1; c.done = 1'b1; q.push_back(c);
    endtask

    // RX model: turnaround, optional RX CMD, n bytes (one idle gap before byte 'gap'), end, turnaround.
    task automatic gen_rx(input logic [7:0] rc, input logic [31:0] bytes, input int n,
                          input int gap, input bit with_cmd, input logic [7:0] din0);
        cyc_t c;
        bit   gd;
        int   j;
        c = blank(); c.rxcmd_req = with_cmd; c.rx_req = n > 0; c.rxcmd_data = rc;
        c.din = din0; c.dir = 1'b1; q.push_back(c);
        c = blank(); c.rxcmd_req = with_cmd; c.rx_req = n > 0; c.rxcmd_data = rc; c.dir = 1'b1;
        if (with_cmd) begin c.dout = rc; c.ack = 1'b1; end else c.rdy = 1'b1;
        q.push_back(c);
        if (with_cmd) begin
            c = blank(); c.rxcmd_data = rc; c.rx_req = n > 0;
            if (n > 0) begin c.dir = 1'b1; c.dout = rc; c.rdy = 1'b1; end
            q.push_back(c);
        end
        gd = 1'b0;
        j = 0;
        while (j < n) begin
            c = blank(); c.rxcmd_data = rc; c.rx_req = 1'b1; c.dir = 1'b1;
            if (j == gap && !gd) begin
                c.dout = rc;
                c.rdy = 1'b1;
                gd = 1'b1;
            end else begin
                c.rx_valid = 1'b1;
                c.rx_data = bytes[8*j+:8];
                c.rx_last = j == n - 1;
                c.dout = bytes[8*j+:8];
                c.nxt = 1'b1;
                c.rdy = j != n - 1;
                j++;
            end
            q.push_back(c);
        end
        if (n > 0) begin c = blank(); c.rxcmd_data = rc; q.push_back(c); end
        c = blank(); c.rxcmd_data = rc; q.push_back(c);
    endtask

    task automatic drive(input cyc_t c);
        stp = c.stp; data_in = c.din; rx_req = c.rx_req; rxcmd_req = c.rxcmd_req;
        rx_valid = c.rx_valid; rx_last = c.rx_last; rx_data = c.rx_data;
        rxcmd_data = c.rxcmd_data; tx_ready = c.tx_ready; reg_rdata = c.rdata;
    endtask

    task automatic compare(input cyc_t c);
        check("dir", 8'(dir), 8'(c.dir));
        check("nxt", 8'(nxt), 8'(c.nxt));
        check("data_out", data_out, c.dout);
        check("tx_cmd_valid", 8'(tx_cmd_valid), 8'(c.tcv));
        check("tx_data_valid", 8'(tx_data_valid), 8'(c.tdv));
        check("tx_done", 8'(tx_done), 8'(c.done));
        check("reg_we", 8'(reg_we), 8'(c.we));
        check("rxcmd_ack", 8'(rxcmd_ack), 8'(c.ack));
        check("rx_ready", 8'(rx_ready), 8'(c.rdy));
        if (c.tcv || c.tdv) check("tx_data", tx_data, c.txd);
        if (c.we) begin
            check("reg_addr", 8'(reg_addr), 8'(c.addr));
            check("reg_wdata", reg_wdata, c.wdata);
        end
        if (tx_cmd_valid) n_tcv++;
        if (tx_data_valid) got.push_back(tx_data);
        if (tx_done) n_done++;
        if (reg_we) n_we++;
        if (rxcmd_ack) n_ack++;
        if (dir) n_dir++;
        if (dir && data_out == 8'h77) n77++;
    endtask

    task automatic run();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            drive(c);
            @(posedge clock);
            @(negedge clock);
            cyc_n++;
            compare(c);
        end
    endtask

    task automatic snap();
        b_tcv = n_tcv; b_done = n_done; b_we = n_we; b_ack = n_ack; b_dir = n_dir; b77 = n77;
        got.delete();
    endtask

    task automatic pin_tx(input string nm);
        check({nm, "_tcv_count"}, 8'(n_tcv - b_tcv), 8'd1);
        check({nm, "_done_count"}, 8'(n_done - b_done), 8'd1);
        check({nm, "_byte_count"}, 8'(got.size()), 8'd2);
        check({nm, "_byte0"}, got.size() > 0 ? got[0] : 8'hxx, 8'hC3);
        check({nm, "_byte1"}, got.size() > 1 ? got[1] : 8'hxx, 8'h5A);
    endtask

    initial begin
        cyc_t c;
        @(posedge clock);
        #1;
        check("rst_dir", 8'(dir), 8'd0);
        check("rst_nxt", 8'(nxt), 8'd0);
        check("rst_data_out", data_out, 8'd0);
        check("rst_tx_data", tx_data, 8'd0);
        check("rst_pulses", 8'({tx_cmd_valid, tx_data_valid, tx_done, reg_we, rxcmd_ack}), 8'd0);
        check("rst_rx_ready", 8'(rx_ready), 8'd0);
        @(negedge clock);
        reset = 1'b0;

        // transmit, with a cmd-type-00 byte ignored first
        snap();
        c = blank(); c.din = 8'h3F; q.push_back(c);
        idle(1);
        gen_tx(8'h41, 32'h0000_5AC3, 2, '1);
        idle(1);
        run();
        pin_tx("tx");

        // transmit throttled by tx_ready
        snap();
        gen_tx(8'h41, 32'h0000_5AC3, 2, 16'hFFFD);
        idle(1);
        run();
        pin_tx("tx_throttle");

        // register write with one wait cycle before stp
        snap();
        c = blank(); c.din = 8'h8A; c.nxt = 1'b1; q.push_back(c);
        c = blank(); c.din = 8'h8A; c.nxt = 1'b1; q.push_back(c);
        c = blank(); c.din = 8'h3C; q.push_back(c);
        idle(1);
        c = blank(); c.stp = 1'b1; c.we = 1'b1; c.addr = 6'h0A; c.wdata = 8'h3C; q.push_back(c);
        idle(1);
        run();
        check("regw_we_count", 8'(n_we - b_we), 8'd1);
        check("regw_dir_cycles", 8'(n_dir - b_dir), 8'd0);

        // register read; link activity during the link turnaround is ignored
        snap();
        c = blank(); c.rdata = 8'h77; c.din = 8'hC4; c.nxt = 1'b1; q.push_back(c);
        c = blank(); c.rdata = 8'h77; c.din = 8'hC4; c.dir = 1'b1; q.push_back(c);
        c = blank(); c.rdata = 8'h77; c.dir = 1'b1; c.dout = 8'h77; q.push_back(c);
        c = blank(); c.rdata = 8'h77; q.push_back(c);
        c = blank(); c.rdata = 8'h77; c.din = 8'hFF; c.stp = 1'b1; q.push_back(c);
        c = blank(); c.rdata = 8'h77; q.push_back(c);
        run();
        check("regr_dir_cycles", 8'(n_dir - b_dir), 8'd2);
        check("regr_data_cycles", 8'(n77 - b77), 8'd1);

        // RX packet with RX CMD and a mid-stream gap
        snap();
        gen_rx(8'h4E, 32'h0010_002D, 3, 1, 1'b1, 8'h00);
        run();
        check("rx_ack_count", 8'(n_ack - b_ack), 8'd1);
        check("rx_dir_cycles", 8'(n_dir - b_dir), 8'd7);

        // RX CMD only
        snap();
        gen_rx(8'h5D, 32'h0, 0, -1, 1'b1, 8'h00);
        run();
        check("rxcmd_ack_count", 8'(n_ack - b_ack), 8'd1);
        check("rxcmd_dir_cycles", 8'(n_dir - b_dir), 8'd2);

        // collision: PHY request and TX CMD at the same IDLE edge, then link retry
        snap();
        gen_rx(8'h4E, 32'h0000_0099, 1, -1, 1'b0, 8'h41);
        run();
        check("collision_tcv_count", 8'(n_tcv - b_tcv), 8'd0);
        snap();
        gen_tx(8'h41, 32'h0000_5AC3, 2, '1);
        idle(1);
        run();
        pin_tx("retry");

        // asynchronous reset in the middle of TXDATA
        gen_tx(8'h41, 32'h0000_5AC3, 2, '1);
        while (q.size() > 3) void'(q.pop_back());
        run();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_dir", 8'(dir), 8'd0);
        check("midrst_nxt", 8'(nxt), 8'd0);
        check("midrst_tdv", 8'(tx_data_valid), 8'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(blank());
        snap();
        gen_tx(8'h41, 32'h0000_5AC3, 2, '1);
        idle(1);
        run();
        pin_tx("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
